// File: rtl/fibo_pkg.sv
// Shared encodings for the Fibonacci controller: FSM states, ALU opcodes,
// register-file map and the datapath control word.
package fibo_pkg;

  localparam int unsigned STATE_W = 4;
  localparam int unsigned OP_W    = 3;
  localparam int unsigned ADDR_W  = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE   = 4'd0,
    LD_N   = 4'd1,
    LD_A   = 4'd2,
    LD_B   = 4'd3,
    LD_ONE = 4'd4,
    CHECK  = 4'd5,
    ADD    = 4'd6,
    SUB    = 4'd7,
    DEC    = 4'd8,
    OUT    = 4'd9,
    DONE   = 4'd10
  } state_t;

  // Must match the ALU's own opcode decode
  localparam logic [OP_W-1:0] ALU_PASS = 3'b000;
  localparam logic [OP_W-1:0] ALU_ADD  = 3'b001;
  localparam logic [OP_W-1:0] ALU_SUB  = 3'b010;

  // R0 loop counter, R1 a, R2 b, R3 constant one
  localparam logic [ADDR_W-1:0] R_CNT = 2'd0;
  localparam logic [ADDR_W-1:0] R_A   = 2'd1;
  localparam logic [ADDR_W-1:0] R_B   = 2'd2;
  localparam logic [ADDR_W-1:0] R_ONE = 2'd3;

  typedef enum logic [1:0] {
    CNT_ZERO = 2'd0,
    CNT_ONE  = 2'd1,
    CNT_N    = 2'd2
  } count_sel_t;

  typedef struct packed {
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] wrt_adder;
    logic              wrt_en;
    logic              load_data;
    logic [ADDR_W-1:0] rd_addr1;
    logic [ADDR_W-1:0] rd_addr2;
    logic [OP_W-1:0]   alu_opcode;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '{
    busy:       1'b0,
    done:       1'b0,
    wrt_adder:  R_CNT,
    wrt_en:     1'b0,
    load_data:  1'b0,
    rd_addr1:   R_CNT,
    rd_addr2:   R_CNT,
    alu_opcode: ALU_PASS
  };

endpackage

// File: rtl/fibo_ctrl_decode.sv
// Moore decode of the controller state into the datapath control word and
// the constant/operand value presented on count.
module fibo_ctrl_decode
  import fibo_pkg::*;
#(
  parameter int unsigned size = 4
) (
  input  state_t          state,
  input  logic [size-1:0] n_reg,
  output ctrl_t           ctrl,
  output logic [size-1:0] count
);

  count_sel_t count_sel;

  always_comb begin
    ctrl      = CTRL_IDLE;
    count_sel = CNT_ZERO;
    case (state)
      LD_N: begin
        ctrl.busy      = 1'b1;
        ctrl.wrt_en    = 1'b1;
        ctrl.load_data = 1'b1;
        ctrl.wrt_adder = R_CNT;
        count_sel      = CNT_N;
      end
      LD_A: begin
        ctrl.busy      = 1'b1;
        ctrl.wrt_en    = 1'b1;
        ctrl.load_data = 1'b1;
        ctrl.wrt_adder = R_A;
        count_sel      = CNT_ZERO;
      end
      LD_B: begin
        ctrl.busy      = 1'b1;
        ctrl.wrt_en    = 1'b1;
        ctrl.load_data = 1'b1;
        ctrl.wrt_adder = R_B;
        count_sel      = CNT_ONE;
      end
      LD_ONE: begin
        ctrl.busy      = 1'b1;
        ctrl.wrt_en    = 1'b1;
        ctrl.load_data = 1'b1;
        ctrl.wrt_adder = R_ONE;
        count_sel      = CNT_ONE;
      end
      CHECK: begin
        ctrl.busy       = 1'b1;
        ctrl.rd_addr1   = R_CNT;
        ctrl.alu_opcode = ALU_PASS;
      end
      ADD: begin
        ctrl.busy       = 1'b1;
        ctrl.wrt_en     = 1'b1;
        ctrl.wrt_adder  = R_B;
        ctrl.rd_addr1   = R_A;
        ctrl.rd_addr2   = R_B;
        ctrl.alu_opcode = ALU_ADD;
      end
      // b_new - a recovers the old b even when the add wrapped
      SUB: begin
        ctrl.busy       = 1'b1;
        ctrl.wrt_en     = 1'b1;
        ctrl.wrt_adder  = R_A;
        ctrl.rd_addr1   = R_B;
        ctrl.rd_addr2   = R_A;
        ctrl.alu_opcode = ALU_SUB;
      end
      DEC: begin
        ctrl.busy       = 1'b1;
        ctrl.wrt_en     = 1'b1;
        ctrl.wrt_adder  = R_CNT;
        ctrl.rd_addr1   = R_CNT;
        ctrl.rd_addr2   = R_ONE;
        ctrl.alu_opcode = ALU_SUB;
      end
      OUT: begin
        ctrl.busy       = 1'b1;
        ctrl.rd_addr1   = R_A;
        ctrl.alu_opcode = ALU_PASS;
      end
      DONE: begin
        ctrl.busy = 1'b1;
        ctrl.done = 1'b1;
      end
      default: ctrl = CTRL_IDLE;
    endcase
  end

  always_comb begin
    count = '0;
    case (count_sel)
      CNT_N:   count = n_reg;
      CNT_ONE: count = size'(1);
      default: count = '0;
    endcase
  end

endmodule

// File: rtl/fibo_controller.sv
// Controller that sequences the 4x4 register-file/ALU datapath to compute
// fib(n) mod 2^size; holds state, the captured index and the result.
module fibo_controller
  import fibo_pkg::*;
#(
  parameter int unsigned size = 4
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              start,
  input  logic [size-1:0]   n,
  output logic              busy,
  output logic              done,
  output logic [size-1:0]   result,
  output logic [ADDR_W-1:0] wrt_adder,
  output logic              wrt_en,
  output logic              load_data,
  output logic [ADDR_W-1:0] rd_addr1,
  output logic [ADDR_W-1:0] rd_addr2,
  output logic [OP_W-1:0]   alu_opcode,
  output logic [size-1:0]   count,
  input  logic [size-1:0]   data_out,
  input  logic              zero_flag
);

  state_t          state;
  state_t          state_nxt;
  logic [size-1:0] n_reg;
  ctrl_t           ctrl;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state  <= IDLE;
      n_reg  <= '0;
      result <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start) n_reg <= n;
      // data_out was latched on the negedge from the R1 pass-through
      if (state == OUT) result <= data_out;
    end
  end

  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE:    state_nxt = start ? LD_N : IDLE;
      LD_N:    state_nxt = LD_A;
      LD_A:    state_nxt = LD_B;
      LD_B:    state_nxt = LD_ONE;
      LD_ONE:  state_nxt = CHECK;
      CHECK:   state_nxt = zero_flag ? OUT : ADD;
      ADD:     state_nxt = SUB;
      SUB:     state_nxt = DEC;
      DEC:     state_nxt = CHECK;
      OUT:     state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  fibo_ctrl_decode #(.size(size)) u_decode (
    .state (state),
    .n_reg (n_reg),
    .ctrl  (ctrl),
    .count (count)
  );

  assign busy       = ctrl.busy;
  assign done       = ctrl.done;
  assign wrt_adder  = ctrl.wrt_adder;
  assign wrt_en     = ctrl.wrt_en;
  assign load_data  = ctrl.load_data;
  assign rd_addr1   = ctrl.rd_addr1;
  assign rd_addr2   = ctrl.rd_addr2;
  assign alu_opcode = ctrl.alu_opcode;

endmodule

// File: tb/tb_fibo_controller.sv
// Bench for fibo_controller driving a behavioural register file/ALU datapath;
// results and latencies are compared against a plain Fibonacci reference.
module tb_fibo_controller;
  import fibo_pkg::*;

  localparam int unsigned W = 4;

  logic          Clk;
  logic          Reset;
  logic          start;
  logic [W-1:0]  n;
  logic          busy;
  logic          done;
  logic [W-1:0]  result;
  logic [1:0]    wrt_adder;
  logic          wrt_en;
  logic          load_data;
  logic [1:0]    rd_addr1;
  logic [1:0]    rd_addr2;
  logic [2:0]    alu_opcode;
  logic [W-1:0]  count;
  logic [W-1:0]  data_out;
  logic          zero_flag;

  logic [W-1:0]  rf [4];
  logic [W-1:0]  alu_res;

  int n_checks = 0;
  int n_fails  = 0;
  int prev_res = 0;

  fibo_controller #(.size(W)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .start      (start),
    .n          (n),
    .busy       (busy),
    .done       (done),
    .result     (result),
    .wrt_adder  (wrt_adder),
    .wrt_en     (wrt_en),
    .load_data  (load_data),
    .rd_addr1   (rd_addr1),
    .rd_addr2   (rd_addr2),
    .alu_opcode (alu_opcode),
    .count      (count),
    .data_out   (data_out),
    .zero_flag  (zero_flag)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // Behavioural datapath: combinational ALU, negedge result latch, posedge write-back
  always_comb begin
    case (alu_opcode)
      3'b001:  alu_res = rf[rd_addr1] + rf[rd_addr2];
      3'b010:  alu_res = rf[rd_addr1] - rf[rd_addr2];
      default: alu_res = rf[rd_addr1];
    endcase
  end

  assign zero_flag = (alu_res == '0);

  always @(negedge Clk) data_out <= alu_res;

  always @(posedge Clk) begin
    if (wrt_en) rf[wrt_adder] <= load_data ? count : data_out;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int fib_ref(input int k);
    int a = 0;
    int b = 1;
    int t;
    for (int i = 0; i < k; i++) begin
      t = (a + b) % 16;
      a = b;
      b = t;
    end
    return a;
  endfunction

  // One full run from IDLE; ends in the IDLE cycle after done with start=keep
  task automatic run_fib(input logic [W-1:0] nv, input bit disturb, input bit keep);
    int exp_res;
    int exp_lat;
    int cyc;
    int done_cyc;
    int adds;
    bit busy_ok;
    exp_res  = fib_ref(int'(nv));
    exp_lat  = 4 * int'(nv) + 7;
    cyc      = 1;
    done_cyc = 0;
    adds     = 0;
    busy_ok  = 1'b1;
    n        = nv;
    start    = 1'b1;
    @(posedge Clk); #1;
    start = disturb;
    check("ld_n_count", int'(count), int'(nv));
    check("ld_n_ctrl", int'({wrt_en, load_data, wrt_adder}), 12);
    check("result_hold_run", int'(result), prev_res);
    while (done_cyc == 0 && cyc < 100) begin
      if (alu_opcode == ALU_ADD) adds++;
      if (!busy) busy_ok = 1'b0;
      if (done) begin
        done_cyc = cyc;
      end else begin
        @(posedge Clk); #1;
        cyc++;
        if (disturb && cyc == 3) begin
          start = 1'b1;
          n     = 4'($urandom_range(0, 15));
        end
      end
    end
    check("done_cycle", done_cyc, exp_lat);
    check("result", int'(result), exp_res);
    check("add_iters", adds, int'(nv));
    check("busy_run", int'(busy_ok), 1);
    start = keep;
    @(posedge Clk); #1;
    check("done_pulse", int'(done), 0);
    check("idle_gap", int'(busy), 0);
    check("result_hold_idle", int'(result), exp_res);
    prev_res = exp_res;
  endtask

  initial begin
    int waited;
    Reset = 1'b1;
    start = 1'b0;
    n     = '0;
    repeat (2) @(posedge Clk);
    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_result", int'(result), 0);
    check("rst_wr", int'({wrt_en, load_data, wrt_adder}), 0);
    check("rst_rd", int'({rd_addr1, rd_addr2}), 0);
    check("rst_op", int'(alu_opcode), int'(ALU_PASS));
    check("rst_count", int'(count), 0);
    Reset = 1'b0;
    @(posedge Clk); #1;
    check("idle_no_start", int'(busy), 0);

    run_fib(4'd0, 1'b0, 1'b0);
    run_fib(4'd1, 1'b0, 1'b0);
    run_fib(4'd7, 1'b0, 1'b0);
    run_fib(4'd8, 1'b0, 1'b0);
    run_fib(4'd15, 1'b0, 1'b0);
    run_fib(4'd6, 1'b1, 1'b0);

    run_fib(4'd2, 1'b0, 1'b1);
    run_fib(4'd3, 1'b0, 1'b1);
    run_fib(4'd5, 1'b0, 1'b0);

    repeat (10) begin
      run_fib(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    start = 1'b0;
    run_fib(4'd7, 1'b0, 1'b0);

    // Reset while the n=5 loop is in ADD
    n     = 4'd5;
    start = 1'b1;
    @(posedge Clk); #1;
    start  = 1'b0;
    waited = 0;
    while (alu_opcode != ALU_ADD && waited < 20) begin
      @(posedge Clk); #1;
      waited++;
    end
    check("reach_add", int'(alu_opcode), int'(ALU_ADD));
    #1 Reset = 1'b1;
    #1;
    check("midrst_busy", int'(busy), 0);
    check("midrst_done", int'(done), 0);
    check("midrst_result", int'(result), 0);
    @(posedge Clk); #1;
    Reset = 1'b0;
    @(posedge Clk); #1;
    check("midrst_idle", int'(busy), 0);
    prev_res = 0;
    run_fib(4'd4, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
